wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface.
- Selects the write-back value (ALU result or memory load data) from the MEM/WB register outputs and commits it to a 32-entry architectural register file.
- Serves the ID stage through two combinational read ports with same-cycle write-through bypass.
- Keeps a retired-write counter for debug and performance visibility.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  global run enable; no state changes while 0.
- wb_regwrite_i  input  1  RegWrite from MEM/WB.
- wb_memreg_i  input  1  MemtoReg from MEM/WB; 1 selects load data.
- wb_rd_addr_i  input  ADDR_W  destination register from MEM/WB.
- wb_alu_data_i  input  DATA_W  ALU result from MEM/WB.
- wb_mem_data_i  input  DATA_W  load data from MEM/WB.
- rs1_addr_i  input  ADDR_W  read port 1 address (ID stage).
- rs2_addr_i  input  ADDR_W  read port 2 address (ID stage).
- rs1_data_o  output  DATA_W  read port 1 data, combinational.
- rs2_data_o  output  DATA_W  read port 2 data, combinational.
- wb_data_o  output  DATA_W  selected write-back value, combinational; feeds the forwarding unit.
- wb_count_o  output  CNT_W  number of committed register writes, registered.

Behaviour:
- Reset is rst_i, asynchronous and active-high; clock is clk_i. Reset clears all 2**ADDR_W entries to 0 and clears wb_count_o to 0.
- Combinational outputs during reset:
  - rs1_data_o and rs2_data_o read the cleared array, so they are 0 unless the bypass applies.
  - wb_data_o follows the mux.
- Write-back mux: wb_data_o = wb_memreg_i ? wb_mem_data_i : wb_alu_data_i. It is purely combinational and independent of start_i.
- Commit condition: we = start_i & wb_regwrite_i & (wb_rd_addr_i != 0).
  - On a rising clk_i edge with we=1, entry[wb_rd_addr_i] <= wb_data_o and wb_count_o <= wb_count_o + 1.
  - Write latency is 1 cycle: the array shows the new value after the edge.
- wb_count_o wraps from all-ones to 0. No saturation.
- Register x0:
  - Entry 0 is never written and always reads 0, including through the bypass.
  - A write to x0 with wb_regwrite_i=1 does not increment the counter.
- Read ports:
  - rsN_data_o = (rsN_addr_i == 0) ? 0 : (we & rsN_addr_i == wb_rd_addr_i) ? wb_data_o : entry[rsN_addr_i].
  - Write-first bypass gives the ID stage the value being retired in the same cycle, with no extra stall.
  - Both ports may address the same register; both return identical data.
- start_i=0:
  - No write, no counter change, no bypass (we=0).
  - Reads return stored array contents.
- Reset asserted mid-operation: the pending write is discarded immediately and the array is zero after rst_i deasserts. The first commit is possible on the first rising edge with rst_i low.
- Unknown inputs: X on wb_rd_addr_i is only permitted while we=0. The bench asserts this.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO = 0.
  - Write-back select encoding: WB_SEL_ALU = 0, WB_SEL_MEM = 1.
- This top module keeps the write-back mux, commit logic and counter.
- One natural sub-module, regfile_2r1w: the storage array with two combinational read ports, one synchronous write port and x0 forcing. The bypass stays in the top.

Test Plan:
- Reset then read: pulse rst_i, read rs1=5, rs2=31 -> rs1_data_o=0, rs2_data_o=0, wb_count_o=0.
- ALU write-back:
  - Stimulus: start_i=1, regwrite=1, memreg=0, rd=3, alu=0x0000_1234, mem=0xDEAD_BEEF, one edge.
  - Response: entry 3 reads 0x0000_1234 on the next cycle; wb_count_o=1.
- Same-cycle bypass:
  - Stimulus: rd=7, memreg=1, mem=0xCAFE_F00D, rs1=rs2=7 in the same cycle before the edge.
  - Response: both read 0xCAFE_F00D before the edge; the array holds it after the edge.
- x0 protection: regwrite=1, rd=0, alu=0xFFFF_FFFF, rs1=0 -> rs1_data_o=0 before and after the edge; wb_count_o unchanged.
- Stall and disable: start_i=0, regwrite=1, rd=9, alu=0x55 for 3 edges -> entry 9 keeps its prior value; rs1=9 returns the old value; counter unchanged.
- Async reset mid-stream and wrap:
  - Stimulus: write 0xA5 to rd=4, assert rst_i between edges.
  - Response: rs1=4 reads 0 immediately and wb_count_o=0.
  - Separately, force the counter to all-ones (CNT_W=4 build) and commit one write -> wb_count_o=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage and its register file.
package wb_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Architectural register storage: two combinational read ports, one synchronous
// write port, entry 0 hard-wired to zero.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array; a reset clears every entry, writes to entry 0 are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != ZERO_ADDR)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports force zero for entry 0.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != ZERO_ADDR) begin
      rdata1_o = mem_q[raddr1_i];
    end else begin
      rdata1_o = '0;
    end
    if (raddr2_i != ZERO_ADDR) begin
      rdata2_o = mem_q[raddr2_i];
    end else begin
      rdata2_o = '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: write-back select, register-file commit with write-first
// bypass to the ID read ports, and a retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              wb_regwrite_i,
  input  logic              wb_memreg_i,
  input  logic [ADDR_W-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_alu_data_i,
  input  logic [DATA_W-1:0] wb_mem_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  wb_count_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  wb_sel_e           wb_sel;
  logic              we;
  logic [DATA_W-1:0] arr1_data;
  logic [DATA_W-1:0] arr2_data;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign wb_sel = wb_sel_e'(wb_memreg_i);
  assign we     = start_i & wb_regwrite_i & (wb_rd_addr_i != ZERO_ADDR);

  // Write-back value select.
  always_comb begin
    wb_data_o = wb_alu_data_i;
    case (wb_sel)
      WB_SEL_MEM: wb_data_o = wb_mem_data_i;
      WB_SEL_ALU: wb_data_o = wb_alu_data_i;
      default:    wb_data_o = wb_alu_data_i;
    endcase
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (we),
    .waddr_i  (wb_rd_addr_i),
    .wdata_i  (wb_data_o),
    .raddr1_i (rs1_addr_i),
    .raddr2_i (rs2_addr_i),
    .rdata1_o (arr1_data),
    .rdata2_o (arr2_data)
  );

  // Write-first bypass so ID sees the value retiring this cycle; x0 stays zero.
  always_comb begin
    rs1_data_o = arr1_data;
    rs2_data_o = arr2_data;
    if (rs1_addr_i == ZERO_ADDR) begin
      rs1_data_o = '0;
    end else if (we && (rs1_addr_i == wb_rd_addr_i)) begin
      rs1_data_o = wb_data_o;
    end else begin
      rs1_data_o = arr1_data;
    end
    if (rs2_addr_i == ZERO_ADDR) begin
      rs2_data_o = '0;
    end else if (we && (rs2_addr_i == wb_rd_addr_i)) begin
      rs2_data_o = wb_data_o;
    end else begin
      rs2_data_o = arr2_data;
    end
  end

  // Retired-write counter next state; wraps naturally.
  always_comb begin
    if (we) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wb_count_o = cnt_q;

endmodule
